// File: rtl/gray_scale_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gray_scale_ctrl
// Description : Frame sequencer for the gray-scale converter. Accepts RGB
//               pixels, strobes them into the converter core, and queues the
//               gray results with SOF/EOL/EOF tags in a credit-managed FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_scale_ctrl #(
    parameter int MAX_PIXEL_BITS  = 24,
    parameter int PIXEL_WIDTH_OUT = 8,
    parameter int IMG_WIDTH       = 320,
    parameter int IMG_HEIGHT      = 240,
    parameter int OUT_DEPTH       = 4
) (
    input  logic                       clk_i,
    input  logic                       nreset_i,
    input  logic                       start_i,
    input  logic                       in_valid_i,
    input  logic [MAX_PIXEL_BITS-1:0]  in_px_rgb_i,
    output logic                       in_ready_o,
    output logic                       gc_px_rdy_o,
    output logic [MAX_PIXEL_BITS-1:0]  gc_px_rgb_o,
    input  logic                       gc_px_rdy_i,
    input  logic [PIXEL_WIDTH_OUT-1:0] gc_px_gray_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PIXEL_WIDTH_OUT-1:0] out_px_gray_o,
    output logic                       out_sof_o,
    output logic                       out_eol_o,
    output logic                       out_eof_o,
    output logic                       busy_o,
    output logic                       frame_done_o,
    output logic                       overflow_o
);

    localparam int COL_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PTR_W   = $clog2(OUT_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = PIXEL_WIDTH_OUT + 3;

    localparam logic [COL_W-1:0] C_COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(OUT_DEPTH);
    localparam logic [CNT_W:0]   C_DEPTH_EXT = (CNT_W + 1)'(OUT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [COL_W-1:0]            col_q;
    logic [ROW_W-1:0]            row_q;
    logic [1:0]                  inflight_q;
    logic                        gc_rdy_q;
    logic [MAX_PIXEL_BITS-1:0]   gc_rgb_q;
    logic [2:0]                  tag_s1_q;   // {sof, eol, eof}, aligned with converter strobe
    logic [2:0]                  tag_s2_q;   // aligned with converter result
    logic [ENTRY_W-1:0]          mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        overflow_q;

    logic                        w_accept;
    logic                        w_col_last;
    logic                        w_row_last;
    logic                        w_last_px;
    logic [2:0]                  w_tags;
    logic [CNT_W:0]              w_used;
    logic                        w_fifo_empty;
    logic                        w_fifo_full;
    logic                        w_push;
    logic                        w_pop;
    logic [ENTRY_W-1:0]          w_head;

    // Credits cover both queued entries and pixels still inside the converter,
    // so a result always finds a free FIFO slot.
    assign w_used       = {1'b0, count_q} + {{(CNT_W - 1){1'b0}}, inflight_q};
    assign in_ready_o   = (state_q == S_RUN) && (w_used < C_DEPTH_EXT);
    assign w_accept     = in_valid_i && in_ready_o;
    assign w_col_last   = (col_q == C_COL_LAST);
    assign w_row_last   = (row_q == C_ROW_LAST);
    assign w_last_px    = w_col_last && w_row_last;
    assign w_tags       = {(col_q == '0) && (row_q == '0), w_col_last, w_last_px};

    assign w_fifo_empty = (count_q == '0);
    assign w_fifo_full  = (count_q == C_DEPTH);
    assign w_push       = gc_px_rdy_i && !w_fifo_full;
    assign w_pop        = out_ready_i && !w_fifo_empty;
    assign w_head       = mem_q[rd_ptr_q];

    assign out_valid_o   = !w_fifo_empty;
    assign out_px_gray_o = out_valid_o ? w_head[PIXEL_WIDTH_OUT-1:0] : '0;
    assign out_sof_o     = out_valid_o && w_head[PIXEL_WIDTH_OUT+2];
    assign out_eol_o     = out_valid_o && w_head[PIXEL_WIDTH_OUT+1];
    assign out_eof_o     = out_valid_o && w_head[PIXEL_WIDTH_OUT];
    assign gc_px_rdy_o   = gc_rdy_q;
    assign gc_px_rgb_o   = gc_rgb_q;
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = (state_q == S_DONE);
    assign overflow_o    = overflow_q;

    // State register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic: drain waits for every pixel to leave the FIFO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (w_accept && w_last_px) state_d = S_DRAIN;
            S_DRAIN: if ((inflight_q == 2'd0) && w_fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                col_q <= '0;
                row_q <= w_row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Pixels issued to the converter but not yet returned; spurious results
    // with nothing outstanding must not wrap the counter.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            inflight_q <= 2'd0;
        end else begin
            case ({w_accept, gc_px_rdy_i})
                2'b10:   inflight_q <= inflight_q + 2'd1;
                2'b01:   if (inflight_q != 2'd0) inflight_q <= inflight_q - 2'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Converter strobe plus the two-stage tag delay matching its fixed latency.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            gc_rdy_q <= 1'b0;
            gc_rgb_q <= '0;
            tag_s1_q <= 3'b000;
            tag_s2_q <= 3'b000;
        end else begin
            gc_rdy_q <= w_accept;
            if (w_accept) begin
                gc_rgb_q <= in_px_rgb_i;
                tag_s1_q <= w_tags;
            end
            tag_s2_q <= tag_s1_q;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (gc_px_rdy_i && w_fifo_full) overflow_q <= 1'b1;
        end
    end

    // FIFO storage; contents are masked by the occupancy so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= {tag_s2_q, gc_px_gray_i};
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_scale_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_scale_ctrl
// Description : Self-checking bench for gray_scale_ctrl (4x2 frame, depth 4)
//               with a behavioural converter and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_scale_ctrl;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int D   = 4;
    localparam int NPX = W * H;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic        clk_i = 1'b0;
    logic        nreset_i;
    logic        start_i;
    logic        in_valid_i;
    logic [23:0] in_px_rgb_i;
    logic        in_ready_o;
    logic        gc_px_rdy_o;
    logic [23:0] gc_px_rgb_o;
    logic        gc_px_rdy_i;
    logic [7:0]  gc_px_gray_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_px_gray_o;
    logic        out_sof_o, out_eol_o, out_eof_o;
    logic        busy_o, frame_done_o, overflow_o;

    always #5 clk_i = ~clk_i;

    gray_scale_ctrl #(
        .MAX_PIXEL_BITS(24), .PIXEL_WIDTH_OUT(8),
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .OUT_DEPTH(D)
    ) dut (
        .clk_i(clk_i), .nreset_i(nreset_i), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_px_rgb_i(in_px_rgb_i), .in_ready_o(in_ready_o),
        .gc_px_rdy_o(gc_px_rdy_o), .gc_px_rgb_o(gc_px_rgb_o),
        .gc_px_rdy_i(gc_px_rdy_i), .gc_px_gray_i(gc_px_gray_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_px_gray_o(out_px_gray_o), .out_sof_o(out_sof_o),
        .out_eol_o(out_eol_o), .out_eof_o(out_eof_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .overflow_o(overflow_o)
    );

    // Behavioural converter: luma weights summing to 234/255, one-cycle latency.
    function automatic logic [7:0] gray_of(input logic [23:0] rgb);
        int s;
        s = int'(rgb[23:16]) * 70 + int'(rgb[15:8]) * 142 + int'(rgb[7:0]) * 22;
        return 8'(s / 255);
    endfunction

    logic conv_rdy;
    logic [7:0] conv_gray;
    logic inject;
    assign gc_px_rdy_i  = conv_rdy | inject;
    assign gc_px_gray_i = conv_gray;

    always @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            conv_rdy  <= 1'b0;
            conv_gray <= 8'h00;
        end else begin
            conv_rdy  <= gc_px_rdy_o;
            conv_gray <= gray_of(gc_px_rgb_o);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phase, pixels accepted in this frame, pixels
    // accepted but not yet delivered, and the expected output records.
    int          m_phase, m_idx, m_out;
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];
    bit          prev_acc;
    logic [23:0] prev_rgb;
    bit          mon_rdy, mon_acc, mon_pop;
    logic [10:0] mon_e, mon_g;

    always @(negedge clk_i) begin
        if (!nreset_i) begin
            m_phase  = P_IDLE;
            m_idx    = 0;
            m_out    = 0;
            prev_acc = 1'b0;
            prev_rgb = '0;
            exp_q.delete();
        end else begin
            mon_rdy = (m_phase == P_RUN) && (m_out < D);
            chk("in_ready", in_ready_o, mon_rdy);
            chk("busy", busy_o, m_phase != P_IDLE);
            chk("frame_done", frame_done_o, m_phase == P_DONE);
            chk("gc_px_rdy", gc_px_rdy_o, prev_acc);
            if (prev_acc) chk("gc_px_rgb", gc_px_rgb_o, prev_rgb);
            mon_g   = {out_px_gray_o, out_sof_o, out_eol_o, out_eof_o};
            mon_pop = 1'b0;
            if (out_valid_o) begin
                chk("out_has_expect", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0 && out_ready_i) begin
                    mon_e = exp_q.pop_front();
                    chk("out_px", mon_g, mon_e);
                    got_q.push_back(mon_g);
                    mon_pop = 1'b1;
                end
            end else begin
                chk("idle_head", mon_g, 0);
            end
            mon_acc = in_valid_i && mon_rdy;
            case (m_phase)
                P_IDLE: if (start_i) begin m_phase = P_RUN; m_idx = 0; end
                P_RUN: if (mon_acc) begin
                    exp_q.push_back({gray_of(in_px_rgb_i), m_idx == 0,
                                     (m_idx % W) == W - 1, m_idx == NPX - 1});
                    m_idx++;
                    if (m_idx == NPX) m_phase = P_DRAIN;
                end
                P_DRAIN: if (m_out == 0) m_phase = P_DONE;
                default: m_phase = P_IDLE;
            endcase
            m_out    = m_out + int'(mon_acc) - int'(mon_pop);
            prev_acc = mon_acc;
            prev_rgb = in_px_rgb_i;
        end
    end

    typedef struct {
        logic [23:0] rgb;
        logic [10:0] exp;   // {gray, sof, eol, eof}
    } vec_t;
    vec_t tbl[NPX];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    int fd_count;
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        fd_count = 0;
        while (busy_o && n < budget) begin
            fd_count += int'(frame_done_o);
            step();
            n++;
        end
        chk("frame_end_timeout", busy_o, 0);
        chk("model_drained", exp_q.size(), 0);
    endtask

    // Feeds the table as one frame; gap idles in_valid between pixels.
    task automatic send_table(input int gap, input bit start_mid);
        bit a;
        int n;
        for (int i = 0; i < NPX; i++) begin
            in_valid_i  = 1'b1;
            in_px_rgb_i = tbl[i].rgb;
            start_i     = start_mid && (i == 2);
            n = 0;
            do begin
                a = in_ready_o;
                step();
                n++;
            end while (!a && n < 50);
            chk("accept_timeout", a, 1);
            in_valid_i = 1'b0;
            start_i    = 1'b0;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic rand_frame();
        int n;
        start_frame();
        n = 0;
        while (busy_o && n < 400) begin
            in_valid_i  = ($urandom % 4) != 0;
            in_px_rgb_i = 24'($urandom);
            out_ready_i = ($urandom % 3) != 0;
            step();
            n++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        wait_idle(50);
    endtask

    initial begin
        int n, acc;
        for (int k = 0; k < NPX; k++) begin
            tbl[k].rgb = (k % 4 == 0) ? 24'hFF0000 : (k % 4 == 1) ? 24'h00FF00 :
                         (k % 4 == 2) ? 24'h0000FF : 24'h000000;
        end
        tbl[0].exp = {8'h46, 3'b100};
        tbl[1].exp = {8'h8E, 3'b000};
        tbl[2].exp = {8'h16, 3'b000};
        tbl[3].exp = {8'h00, 3'b010};
        tbl[4].exp = {8'h46, 3'b000};
        tbl[5].exp = {8'h8E, 3'b000};
        tbl[6].exp = {8'h16, 3'b000};
        tbl[7].exp = {8'h00, 3'b011};

        nreset_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
        in_px_rgb_i = '0; out_ready_i = 1'b1; inject = 1'b0;
        step(); step();
        chk("reset_outputs", {in_ready_o, gc_px_rdy_o, gc_px_rgb_o, out_valid_o, out_px_gray_o,
                              out_sof_o, out_eol_o, out_eof_o, busy_o, frame_done_o, overflow_o}, 0);
        nreset_i = 1'b1;
        step();

        // No accept while idle even with valid input.
        in_valid_i = 1'b1; in_px_rgb_i = 24'h123456;
        step(); step();
        chk("idle_no_ready", in_ready_o, 0);

        // White frame: latency and a single frame_done pulse.
        got_q.delete();
        in_valid_i = 1'b0;
        start_frame();
        in_valid_i = 1'b1; in_px_rgb_i = 24'hFFFFFF;
        n = 0;
        while (!out_valid_o && n < 10) begin step(); n++; end
        chk("first_out_latency", n, 3);
        chk("first_out_white", {out_px_gray_o, out_sof_o, out_eol_o, out_eof_o}, {8'hEA, 3'b100});
        wait_idle(60);
        in_valid_i = 1'b0;
        chk("white_count", got_q.size(), NPX);
        chk("frame_done_pulses", fd_count, 1);

        // Colour table, back-to-back then with gaps and a stray start.
        for (int pass = 0; pass < 2; pass++) begin
            got_q.delete();
            start_frame();
            send_table(pass, pass == 1);
            wait_idle(60);
            chk("table_count", got_q.size(), NPX);
            for (int i = 0; i < NPX; i++) chk("table_out", got_q[i], tbl[i].exp);
        end

        // Backpressure: credits stop at the FIFO depth.
        got_q.delete();
        out_ready_i = 1'b0;
        start_frame();
        acc = 0;
        in_valid_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_px_rgb_i = {3{8'(acc * 20)}};
            acc += int'(in_ready_o);
            step();
        end
        chk("bp_accepted", acc, D);
        chk("bp_ready_low", in_ready_o, 0);
        out_ready_i = 1'b1;
        n = 0;
        while (acc < NPX && n < 100) begin
            in_px_rgb_i = {3{8'(acc * 20)}};
            acc += int'(in_ready_o);
            step();
            n++;
        end
        in_valid_i = 1'b0;
        wait_idle(60);
        chk("bp_count", got_q.size(), NPX);
        chk("bp_no_overflow", overflow_o, 0);

        // Reset after three accepted pixels.
        start_frame();
        acc = 0;
        in_valid_i = 1'b1;
        n = 0;
        while (acc < 3 && n < 20) begin
            in_px_rgb_i = 24'h0F0F0F * acc;
            acc += int'(in_ready_o);
            step();
            n++;
        end
        in_valid_i = 1'b0;
        nreset_i = 1'b0;
        #1;
        chk("midreset_outputs", {in_ready_o, gc_px_rdy_o, gc_px_rgb_o, out_valid_o, out_px_gray_o,
                                 out_sof_o, out_eol_o, out_eof_o, busy_o, frame_done_o, overflow_o}, 0);
        step(); step();
        nreset_i = 1'b1;
        step();
        got_q.delete();
        rand_frame();
        chk("post_reset_count", got_q.size(), NPX);
        chk("post_reset_sof", got_q.size() > 0 ? 32'(got_q[0][2]) : 32'd0, 1);

        for (int f = 0; f < 4; f++) rand_frame();

        // Spurious converter result into a full FIFO.
        out_ready_i = 1'b0;
        start_frame();
        in_valid_i = 1'b1; in_px_rgb_i = 24'h808080;
        for (int c = 0; c < 10; c++) step();
        chk("inj_fifo_full", {in_ready_o, out_valid_o}, 2'b01);
        chk("inj_pre_overflow", overflow_o, 0);
        inject = 1'b1;
        step();
        inject = 1'b0;
        chk("inj_overflow", overflow_o, 1);
        step(); step(); step();
        chk("inj_overflow_sticky", overflow_o, 1);
        out_ready_i = 1'b1;
        n = 0;
        while (m_phase == P_RUN && n < 100) begin step(); n++; end
        in_valid_i = 1'b0;
        wait_idle(60);
        chk("inj_overflow_after_frame", overflow_o, 1);
        nreset_i = 1'b0;
        step(); step();
        nreset_i = 1'b1;
        step();
        chk("inj_overflow_cleared", overflow_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
